// File: rtl/pio_edge_ctrl.sv
// Avalon-MM edge-capture PIO: synchronizes and debounces WIDTH inputs, latches rise/fall
// events in CAPTURE and raises a masked level interrupt. Define PIO_EDGE_DEBOUNCE_EN for debounce counters.
module pio_edge_ctrl #(
  parameter int WIDTH           = 8,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             read,
  input  logic             write,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  logic [WIDTH-1:0] sync1_reg;
  logic [WIDTH-1:0] sync2_reg;
  logic [WIDTH-1:0] db_state;
  logic [WIDTH-1:0] db_prev_reg;
  logic [WIDTH-1:0] mask_reg;
  logic [WIDTH-1:0] mode_reg;
  logic [WIDTH-1:0] cap_reg;
  logic [WIDTH-1:0] cap_next;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] cap_set;
  logic [WIDTH-1:0] cap_clr;
  logic [31:0]      rd_mux;
  logic             wr_en;
  logic             rd_en;
  logic             unused_bits;

  assign wr_en       = chipselect & write;
  assign rd_en       = chipselect & read;
  assign unused_bits = ^{writedata, 32'(DEBOUNCE_CYCLES)};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_reg <= '0;
      sync2_reg <= '0;
    end else begin
      sync1_reg <= in_port;
      sync2_reg <= sync1_reg;
    end
  end

`ifdef PIO_EDGE_DEBOUNCE_EN
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_db
      logic [CNT_W-1:0] cnt_reg;
      logic             db_bit_reg;

      // Counter only runs while the synchronized input disagrees with the debounced state.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          cnt_reg    <= '0;
          db_bit_reg <= 1'b0;
        end else if (sync2_reg[gi] == db_bit_reg) begin
          cnt_reg <= '0;
        end else if (cnt_reg == CNT_LAST) begin
          cnt_reg    <= '0;
          db_bit_reg <= ~db_bit_reg;
        end else begin
          cnt_reg <= cnt_reg + 1'b1;
        end
      end

      assign db_state[gi] = db_bit_reg;
    end
  endgenerate
`else
  logic [WIDTH-1:0] db_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) db_reg <= '0;
    else          db_reg <= sync2_reg;
  end

  assign db_state = db_reg;
`endif

  always_comb begin
    rise     = db_state & ~db_prev_reg;
    fall     = ~db_state & db_prev_reg;
    cap_set  = (mode_reg & fall) | (~mode_reg & rise);
    cap_clr  = '0;
    if (wr_en && address == 2'd3) cap_clr = writedata[WIDTH-1:0];
    // A new event in the same cycle as a clear keeps the bit set.
    cap_next = (cap_reg & ~cap_clr) | cap_set;
    rd_mux   = '0;
    case (address)
      2'd0:    rd_mux = 32'(db_state);
      2'd1:    rd_mux = 32'(mask_reg);
      2'd2:    rd_mux = 32'(mode_reg);
      default: rd_mux = 32'(cap_reg);
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      db_prev_reg <= '0;
      mask_reg    <= '0;
      mode_reg    <= '0;
      cap_reg     <= '0;
      readdata    <= '0;
      irq         <= 1'b0;
    end else begin
      db_prev_reg <= db_state;
      cap_reg     <= cap_next;
      irq         <= |(cap_reg & mask_reg);
      if (wr_en && address == 2'd1) mask_reg <= writedata[WIDTH-1:0];
      if (wr_en && address == 2'd2) mode_reg <= writedata[WIDTH-1:0];
      if (rd_en) readdata <= rd_mux;
    end
  end

endmodule

// File: tb/tb_pio_edge_ctrl.sv
// Directed bench for pio_edge_ctrl; read expectations flow through a scoreboard queue.
// Latency expectations follow PIO_EDGE_DEBOUNCE_EN so the bench works in either build.
module tb_pio_edge_ctrl;
  localparam int WIDTH = 8;
  localparam int DBN   = 4;
`ifdef PIO_EDGE_DEBOUNCE_EN
  localparam int LAT = DBN + 2;
  localparam bit DEB = 1'b1;
`else
  localparam int LAT = 3;
  localparam bit DEB = 1'b0;
`endif

  logic             clk;
  logic             reset_n;
  logic [1:0]       address;
  logic             chipselect;
  logic             read;
  logic             write;
  logic [31:0]      writedata;
  logic [31:0]      readdata;
  logic [WIDTH-1:0] in_port;
  logic             irq;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];

  pio_edge_ctrl #(.WIDTH(WIDTH), .DEBOUNCE_CYCLES(DBN)) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .read(read), .write(write), .writedata(writedata), .readdata(readdata),
    .in_port(in_port), .irq(irq)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic rd(input string tag, input logic [1:0] a, input logic [31:0] exp);
    exp_q.push_back(exp);
    chipselect = 1'b1; read = 1'b1; address = a;
    tick();
    chipselect = 1'b0; read = 1'b0;
    chk(tag, readdata, exp_q.pop_front());
    $display("read  addr=%0d data=0x%08h", a, readdata);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
    tick();
    chipselect = 1'b0; write = 1'b0;
    $display("write addr=%0d data=0x%08h", a, d);
  endtask

  task automatic rdwr(input string tag, input logic [1:0] a, input logic [31:0] d,
                      input logic [31:0] exp);
    exp_q.push_back(exp);
    chipselect = 1'b1; read = 1'b1; write = 1'b1; address = a; writedata = d;
    tick();
    chipselect = 1'b0; read = 1'b0; write = 1'b0;
    chk(tag, readdata, exp_q.pop_front());
    $display("rdwr  addr=%0d wdata=0x%08h rdata=0x%08h", a, d, readdata);
  endtask

  initial begin
    reset_n = 1'b0; address = '0; chipselect = 1'b0; read = 1'b0; write = 1'b0;
    writedata = '0; in_port = '0;
    #12;
    chk("reset_readdata", readdata, 32'h0);
    chk("reset_irq", {31'b0, irq}, 32'h0);
    reset_n = 1'b1;
    rd("reset_mask", 2'd1, 32'h0);
    rd("reset_mode", 2'd2, 32'h0);
    rd("reset_cap", 2'd3, 32'h0);

    // Rise on bit 0: DB changes exactly LAT edges after the input.
    in_port[0] = 1'b1;
    repeat (LAT - 1) tick();
    rd("db0_before", 2'd0, 32'h0);
    rd("db0_after", 2'd0, 32'h1);
    rd("cap0_rise", 2'd3, 32'h1);
    wr(2'd3, 32'h1);
    rd("cap0_clr", 2'd3, 32'h0);

    // Short glitch on bit 1.
    in_port[1] = 1'b1;
    repeat (DBN - 1) tick();
    in_port[1] = 1'b0;
    repeat (LAT + 4) tick();
    rd("glitch_data", 2'd0, 32'h1);
    rd("glitch_cap", 2'd3, DEB ? 32'h0 : 32'h2);
    chk("glitch_irq", {31'b0, irq}, 32'h0);
    wr(2'd3, 32'hFF);

    // Fall capture on bit 2 with interrupt.
    wr(2'd1, 32'h4);
    wr(2'd2, 32'h4);
    in_port[2] = 1'b1;
    repeat (LAT + 3) tick();
    rd("fallmode_no_rise", 2'd3, 32'h0);
    chk("fallmode_irq0", {31'b0, irq}, 32'h0);
    in_port[2] = 1'b0;
    repeat (LAT) tick();
    rd("fall_cap_pre", 2'd3, 32'h0);
    chk("fall_irq_pre", {31'b0, irq}, 32'h0);
    rd("fall_cap", 2'd3, 32'h4);
    chk("fall_irq", {31'b0, irq}, 32'h1);
    wr(2'd3, 32'h4);
    tick();
    chk("fall_irq_clr", {31'b0, irq}, 32'h0);
    rd("fall_cap_clr", 2'd3, 32'h0);

    // Rise on bit 3 coincides with a clear of bit 3: set wins.
    in_port[3] = 1'b1;
    repeat (LAT) tick();
    wr(2'd3, 32'h8);
    rd("set_wins", 2'd3, 32'h8);
    wr(2'd2, 32'h0C);
    rd("mode_keeps_cap", 2'd3, 32'h8);
    wr(2'd1, 32'h8);
    chk("mask_irq_lag", {31'b0, irq}, 32'h0);
    tick();
    chk("mask_irq", {31'b0, irq}, 32'h1);

    rdwr("rdwr_old", 2'd1, 32'hFFFF_FFFF, 32'h8);
    rd("mask_trunc", 2'd1, 32'hFF);
    rd("mode_val", 2'd2, 32'h0C);
    wr(2'd0, 32'hFF);
    rd("data_ro", 2'd0, 32'h09);

    // Reset mid-debounce.
    in_port[4] = 1'b1;
    repeat (2) tick();
    reset_n = 1'b0;
    #1;
    chk("rst_readdata", readdata, 32'h0);
    chk("rst_irq", {31'b0, irq}, 32'h0);
    tick();
    reset_n = 1'b1;
    rd("rst_mask", 2'd1, 32'h0);
    repeat (LAT + 3) tick();
    rd("rst_data", 2'd0, 32'h19);
    rd("rst_cap", 2'd3, 32'h19);

    // Multi-bit change.
    wr(2'd3, 32'hFF);
    in_port = 8'hA5;
    repeat (LAT - 1) tick();
    rd("a5_before", 2'd0, 32'h19);
    rd("a5_after", 2'd0, 32'hA5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pio_edge_ctrl.md
PIO_EDGE_CTRL -- requirements
Module: pio_edge_ctrl

Interface
REQ-001 Parameter WIDTH, 8, number of input bits, legal range 1..32.
REQ-002 Parameter DEBOUNCE_CYCLES, 16, number of consecutive cycles a changed input must hold, legal range 2..65535.
REQ-003 Port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 Port reset_n  input  1  asynchronous, active-low reset.
REQ-005 Port address  input  2  Avalon-MM word address.
REQ-006 Port chipselect  input  1  slave select; read and write are ignored when low.
REQ-007 Port read  input  1  read strobe.
REQ-008 Port write  input  1  write strobe.
REQ-009 Port writedata  input  32  write data.
REQ-010 Port readdata  output  32  registered read data.
REQ-011 Port in_port  input  WIDTH  asynchronous external inputs, such as switches and buttons.
REQ-012 Port irq  output  1  registered, level-high interrupt request.

Function
REQ-013 The block SHALL pass in_port through a 2-flop synchronizer per bit before any other use.
REQ-014 The block SHALL keep one debounced state bit (DB) per input bit.
- Each bit has a counter that increments while the synchronized bit differs from DB.
- The counter clears to 0 on any cycle the two are equal.
- DB SHALL toggle, and the counter SHALL clear, on the edge where the counter equals DEBOUNCE_CYCLES-1 and the inputs still differ.
REQ-015 The block SHALL register DB into DB_prev every cycle.
- Rise on bit i = DB[i] & ~DB_prev[i]; fall on bit i = ~DB[i] & DB_prev[i].
REQ-016 The block SHALL implement this register map, with unused upper bits reading 0:
- Address 0 DATA: read-only DB.
- Address 1 MASK: read/write, WIDTH bits.
- Address 2 MODE: read/write, WIDTH bits; 0 = capture rise, 1 = capture fall.
- Address 3 CAPTURE: read, and write-1-to-clear.
REQ-017 CAPTURE[i] SHALL set on the edge after a qualifying edge for the mode currently in MODE[i].
REQ-018 A write of 1 to CAPTURE[i] SHALL clear it; writes of 0 leave it unchanged.
REQ-019 If a set and a clear of CAPTURE[i] occur in the same cycle, the set SHALL win.
REQ-020 Writes to address 0 SHALL have no effect.
REQ-021 readdata SHALL update on the edge where chipselect&read is sampled high, giving one cycle of latency.
- The value is the zero-extended register selected by address.
- readdata SHALL hold its value when no read occurs.
REQ-022 A read and a write in the same cycle SHALL both take effect; readdata returns the pre-write value.
REQ-023 irq SHALL equal the registered value of |(CAPTURE & MASK), lagging CAPTURE or MASK by one cycle.
REQ-024 Changing MODE SHALL NOT alter existing CAPTURE bits.

Reset
REQ-025 While reset_n is low, the block SHALL asynchronously clear synchronizers, counters, DB, DB_prev, MASK, MODE, CAPTURE, readdata and irq to 0.
REQ-026 Reset asserted mid-debounce or mid-read SHALL discard the pending count or read; the first valid access is on the first edge after reset_n rises.
REQ-027 After reset, inputs held high SHALL debounce to DB=1 and produce a rise capture, which is intended behaviour.

Configuration
REQ-028 Macro PIO_EDGE_DEBOUNCE_EN, when defined, SHALL include the counters of REQ-014.
REQ-029 When PIO_EDGE_DEBOUNCE_EN is undefined, DB SHALL equal the synchronized input registered once, no counters SHALL exist, and DEBOUNCE_CYCLES SHALL be ignored.

Verification
REQ-030 Debounce on: hold in_port[0]=1 for DEBOUNCE_CYCLES+4 cycles, then read address 0 -> readdata=0x00000001; DB rises exactly 2+DEBOUNCE_CYCLES edges after the input change.
REQ-031 Debounce on: pulse in_port[1] high for DEBOUNCE_CYCLES-1 cycles -> DATA stays 0x0, CAPTURE stays 0x0, irq stays 0.
REQ-032 Set MASK=0x04 and MODE=0x04, drive in_port[2] 1 then 0 -> CAPTURE=0x04 only after the fall, irq=1 one cycle later; write 0x04 to address 3 -> CAPTURE=0, irq=0.
REQ-033 Drive a rise on bit 3 in the same cycle as a write of 0x08 to address 3 -> CAPTURE[3]=1.
REQ-034 Assert reset_n low mid-count with MASK=0xFF -> all outputs are 0 immediately; after release, a read of address 1 -> 0x00000000.
REQ-035 Compile without PIO_EDGE_DEBOUNCE_EN, change in_port=0xA5 -> DATA=0xA5 three edges after the change.
